pnr_main: RTL and testbench

- Photon-number-resolving (PNR) pulse classifier.
- Sits between the ADC sample stream and downstream readout/histogram logic.
- `trigger` opens a measurement window and `delayed_trigger` closes it. The peak ADC value inside the window is compared against 8 programmable thresholds to produce a photon number from 0 to 8.
- Keeps a per-photon-number event histogram.

---
 rtl/pnr_pkg.sv | 28 ++
 rtl/pnr_classifier.sv | 20 ++
 rtl/pnr_main.sv | 129 ++++++++++++
 tb/tb_pnr_main.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pnr_pkg.sv
// Shared widths, types and small helpers for the photon-number-resolving classifier.
package pnr_pkg;

  localparam int ADC_W  = 14;
  localparam int N_THR  = 8;
  localparam int CNT_W  = 32;
  localparam int PN_W   = 4;
  localparam int N_BINS = N_THR + 1;

  typedef logic [ADC_W-1:0] adc_t;
  typedef adc_t thr_arr_t [N_THR];
  typedef logic [CNT_W-1:0] cnt_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

  function automatic logic [PN_W-1:0] popcount(input logic [N_THR-1:0] v);
    logic [PN_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_THR; i++) begin
      c = c + {{(PN_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/pnr_classifier.sv
// Combinational threshold bank: peak vs. each threshold, then popcount to a photon number.
module pnr_classifier
  import pnr_pkg::*;
(
  input  adc_t                  peak,
  input  thr_arr_t              thr,
  output logic [N_THR-1:0]      thermo,
  output logic [PN_W-1:0]       photon_num
);

  // Thresholds need not be monotonic, so count set bits rather than find a boundary.
  generate
    for (genvar gi = 0; gi < N_THR; gi++) begin : gen_cmp
      assign thermo[gi] = (peak >= thr[gi]);
    end
  endgenerate

  assign photon_num = popcount(thermo);

endmodule

// File: rtl/pnr_main.sv
// Windowed peak detector and photon-number histogrammer driven by trigger / delayed_trigger.
module pnr_main
  import pnr_pkg::*;
(
  input  logic                    ADC_CLK,
  input  logic                    rstn_i,
  input  logic                    trigger,
  input  logic                    delayed_trigger,
  input  logic [ADC_W-1:0]        pnr_source_sig,
  input  logic [ADC_W-1:0]        adc_photon_threshold_1,
  input  logic [ADC_W-1:0]        adc_photon_threshold_2,
  input  logic [ADC_W-1:0]        adc_photon_threshold_3,
  input  logic [ADC_W-1:0]        adc_photon_threshold_4,
  input  logic [ADC_W-1:0]        adc_photon_threshold_5,
  input  logic [ADC_W-1:0]        adc_photon_threshold_6,
  input  logic [ADC_W-1:0]        adc_photon_threshold_7,
  input  logic [ADC_W-1:0]        adc_photon_threshold_8,
  output logic [PN_W-1:0]         photon_num_o,
  output logic                    photon_valid_o,
  output logic [ADC_W-1:0]        peak_o,
  output logic [N_THR-1:0]        thermo_o,
  output logic                    window_active_o,
  output logic [N_BINS*CNT_W-1:0] hist_o,
  output logic [CNT_W-1:0]        event_cnt_o,
  output logic [CNT_W-1:0]        restart_cnt_o
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]       state_reg;
  adc_t             peak_reg;
  adc_t             final_peak;
  thr_arr_t         thr;
  logic [N_THR-1:0] cls_thermo;
  logic [PN_W-1:0]  cls_num;
  logic             active;
  logic             complete;
  logic             restart;

  logic [PN_W-1:0]  photon_num_reg;
  logic             photon_valid_reg;
  adc_t             peak_out_reg;
  logic [N_THR-1:0] thermo_reg;
  cnt_t             event_cnt_reg;
  cnt_t             restart_cnt_reg;

  assign thr[0] = adc_photon_threshold_1;
  assign thr[1] = adc_photon_threshold_2;
  assign thr[2] = adc_photon_threshold_3;
  assign thr[3] = adc_photon_threshold_4;
  assign thr[4] = adc_photon_threshold_5;
  assign thr[5] = adc_photon_threshold_6;
  assign thr[6] = adc_photon_threshold_7;
  assign thr[7] = adc_photon_threshold_8;

  assign active   = (state_reg == ST_ACTIVE);
  assign complete = active && delayed_trigger;
  assign restart  = active && trigger && !delayed_trigger;

  // The closing-cycle sample still counts toward the window's peak.
  assign final_peak = (pnr_source_sig > peak_reg) ? pnr_source_sig : peak_reg;

  pnr_classifier u_classifier (
    .peak       (final_peak),
    .thr        (thr),
    .thermo     (cls_thermo),
    .photon_num (cls_num)
  );

  always_ff @(posedge ADC_CLK) begin
    if (!rstn_i) begin
      state_reg        <= ST_IDLE;
      peak_reg         <= '0;
      photon_num_reg   <= '0;
      photon_valid_reg <= 1'b0;
      peak_out_reg     <= '0;
      thermo_reg       <= '0;
      event_cnt_reg    <= '0;
      restart_cnt_reg  <= '0;
    end else begin
      photon_valid_reg <= 1'b0;
      // A trigger always (re)opens a window from the current sample, whatever else happens.
      if (trigger) begin
        state_reg <= ST_ACTIVE;
        peak_reg  <= pnr_source_sig;
      end else if (complete) begin
        state_reg <= ST_IDLE;
      end else if (active && (pnr_source_sig > peak_reg)) begin
        peak_reg <= pnr_source_sig;
      end

      if (complete) begin
        photon_num_reg   <= cls_num;
        peak_out_reg     <= final_peak;
        thermo_reg       <= cls_thermo;
        photon_valid_reg <= 1'b1;
        event_cnt_reg    <= sat_inc(event_cnt_reg);
      end

      if (restart) begin
        restart_cnt_reg <= sat_inc(restart_cnt_reg);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_BINS; gi++) begin : gen_hist
      cnt_t bin_reg;
      always_ff @(posedge ADC_CLK) begin
        if (!rstn_i) begin
          bin_reg <= '0;
        end else if (complete && (cls_num == PN_W'(gi))) begin
          bin_reg <= sat_inc(bin_reg);
        end
      end
      assign hist_o[gi*CNT_W +: CNT_W] = bin_reg;
    end
  endgenerate

  assign photon_num_o    = photon_num_reg;
  assign photon_valid_o  = photon_valid_reg;
  assign peak_o          = peak_out_reg;
  assign thermo_o        = thermo_reg;
  assign window_active_o = active;
  assign event_cnt_o     = event_cnt_reg;
  assign restart_cnt_o   = restart_cnt_reg;

endmodule

// File: tb/tb_pnr_main.sv
// Self-checking bench for pnr_main: directed tables, test-plan sequences and random traffic vs. a window model.
module tb_pnr_main;
  import pnr_pkg::*;

  logic        ADC_CLK = 1'b0;
  logic        rstn_i;
  logic        trigger;
  logic        delayed_trigger;
  logic [13:0] sample;
  logic [13:0] thr [8];

  logic [3:0]   photon_num_o;
  logic         photon_valid_o;
  logic [13:0]  peak_o;
  logic [7:0]   thermo_o;
  logic         window_active_o;
  logic [287:0] hist_o;
  logic [31:0]  event_cnt_o;
  logic [31:0]  restart_cnt_o;

  always #4 ADC_CLK = ~ADC_CLK;

  pnr_main dut (
    .ADC_CLK                (ADC_CLK),
    .rstn_i                 (rstn_i),
    .trigger                (trigger),
    .delayed_trigger        (delayed_trigger),
    .pnr_source_sig         (sample),
    .adc_photon_threshold_1 (thr[0]),
    .adc_photon_threshold_2 (thr[1]),
    .adc_photon_threshold_3 (thr[2]),
    .adc_photon_threshold_4 (thr[3]),
    .adc_photon_threshold_5 (thr[4]),
    .adc_photon_threshold_6 (thr[5]),
    .adc_photon_threshold_7 (thr[6]),
    .adc_photon_threshold_8 (thr[7]),
    .photon_num_o           (photon_num_o),
    .photon_valid_o         (photon_valid_o),
    .peak_o                 (peak_o),
    .thermo_o               (thermo_o),
    .window_active_o        (window_active_o),
    .hist_o                 (hist_o),
    .event_cnt_o            (event_cnt_o),
    .restart_cnt_o          (restart_cnt_o)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: the window is simply the list of samples seen since it opened.
  localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;
  bit       m_open;
  int       m_win[$];
  bit       m_valid;
  int       m_num;
  int       m_peak;
  int       m_thermo;
  longint   m_hist[9];
  longint   m_ev;
  longint   m_rs;

  typedef struct {
    bit trig; bit dtrig; int s;
    bit v; int n; int p; bit a; int ev; int rs;
  } vec_t;
  vec_t vt[10];

  function automatic longint sat(input longint v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int pk;
    if (!rstn_i) begin
      m_open = 0; m_win.delete(); m_valid = 0; m_num = 0; m_peak = 0; m_thermo = 0;
      foreach (m_hist[b]) m_hist[b] = 0;
      m_ev = 0; m_rs = 0;
    end else begin
      m_valid = 0;
      if (m_open && delayed_trigger) begin
        m_win.push_back(int'(sample));
        pk = 0;
        foreach (m_win[i]) if (m_win[i] > pk) pk = m_win[i];
        m_thermo = 0; m_num = 0;
        for (int k = 0; k < 8; k++) begin
          if (pk >= int'(thr[k])) begin
            m_thermo = m_thermo | (1 << k);
            m_num++;
          end
        end
        m_peak = pk; m_valid = 1;
        m_hist[m_num] = sat(m_hist[m_num]);
        m_ev = sat(m_ev);
        m_win.delete();
        m_open = trigger;
        if (trigger) m_win.push_back(int'(sample));
      end else if (trigger) begin
        if (m_open) m_rs = sat(m_rs);
        m_open = 1;
        m_win.delete();
        m_win.push_back(int'(sample));
      end else if (m_open) begin
        m_win.push_back(int'(sample));
      end
    end
  endtask

  task automatic check_all();
    chk("valid", photon_valid_o, m_valid);
    chk("active", window_active_o, m_open);
    chk("photon_num", photon_num_o, m_num);
    chk("peak", peak_o, m_peak);
    chk("thermo", thermo_o, m_thermo);
    chk("event_cnt", event_cnt_o, m_ev);
    chk("restart_cnt", restart_cnt_o, m_rs);
    for (int b = 0; b < 9; b++) begin
      chk($sformatf("hist%0d", b), hist_o[b*32 +: 32], m_hist[b]);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge ADC_CLK);
    #1;
    check_all();
    if (m_valid) $display("completion t=%0t num=%0d peak=%0d thermo=%02h", $time, photon_num_o, peak_o, thermo_o);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0; trigger = 1'b0; delayed_trigger = 1'b0;
    step();
    rstn_i = 1'b1;
  endtask

  function automatic longint hist_sum();
    longint s;
    s = 0;
    for (int b = 0; b < 9; b++) s += longint'(hist_o[b*32 +: 32]);
    return s;
  endfunction

  initial begin
    int idx;
    rstn_i = 1'b0; trigger = 1'b0; delayed_trigger = 1'b0; sample = '0;
    for (int k = 0; k < 8; k++) thr[k] = 14'(500 + 1000 * k);

    // Reset held for four cycles.
    repeat (4) step();
    chk("rst_hist_any", {63'd0, |hist_o}, 64'd0);
    chk("rst_active", window_active_o, 0);
    rstn_i = 1'b1;

    // Directed edge cases: stray close, restart, simultaneous close/open.
    vt[0] = '{0, 1, 9000, 0, 0, 0,    0, 0, 0};
    vt[1] = '{1, 0, 3000, 0, 0, 0,    1, 0, 0};
    vt[2] = '{0, 0, 6000, 0, 0, 0,    1, 0, 0};
    vt[3] = '{1, 0, 1000, 0, 0, 0,    1, 0, 1};
    vt[4] = '{0, 0, 2000, 0, 0, 0,    1, 0, 1};
    vt[5] = '{0, 1, 1600, 1, 2, 2000, 0, 1, 1};
    vt[6] = '{1, 1, 5000, 0, 2, 2000, 1, 1, 1};
    vt[7] = '{1, 1, 7000, 1, 7, 7000, 1, 2, 1};
    vt[8] = '{0, 0, 100,  0, 7, 7000, 1, 2, 1};
    vt[9] = '{0, 1, 200,  1, 7, 7000, 0, 3, 1};
    for (int i = 0; i < 10; i++) begin
      trigger = vt[i].trig; delayed_trigger = vt[i].dtrig; sample = 14'(vt[i].s);
      step();
      chk($sformatf("tbl%0d_valid", i), photon_valid_o, vt[i].v);
      chk($sformatf("tbl%0d_num", i), photon_num_o, vt[i].n);
      chk($sformatf("tbl%0d_peak", i), peak_o, vt[i].p);
      chk($sformatf("tbl%0d_active", i), window_active_o, vt[i].a);
      chk($sformatf("tbl%0d_event", i), event_cnt_o, vt[i].ev);
      chk($sformatf("tbl%0d_restart", i), restart_cnt_o, vt[i].rs);
    end
    trigger = 0; delayed_trigger = 0;

    // Constant 4200 for a 10-cycle window.
    do_reset();
    sample = 14'd4200; trigger = 1; step(); trigger = 0;
    repeat (9) step();
    delayed_trigger = 1; step(); delayed_trigger = 0;
    chk("const_valid", photon_valid_o, 1);
    chk("const_num", photon_num_o, 4);
    chk("const_thermo", thermo_o, 8'h0F);
    chk("const_peak", peak_o, 4200);
    chk("const_hist4", hist_o[4*32 +: 32], 1);
    chk("const_event", event_cnt_o, 1);
    step();
    chk("const_valid_drop", photon_valid_o, 0);

    // Ramp whose maximum lands exactly on the closing cycle.
    do_reset();
    sample = 14'd100; trigger = 1; step(); trigger = 0;
    for (int i = 1; i <= 14; i++) begin
      sample = 14'(100 + 500 * i);
      step();
    end
    sample = 14'd7600; delayed_trigger = 1; step(); delayed_trigger = 0;
    chk("ramp_peak", peak_o, 7600);
    chk("ramp_num", photon_num_o, 8);
    chk("ramp_thermo", thermo_o, 8'hFF);

    // Reset in the middle of a window discards it.
    do_reset();
    sample = 14'd5000; trigger = 1; step(); trigger = 0;
    step(); step();
    rstn_i = 0; step(); rstn_i = 1;
    step();
    delayed_trigger = 1; step(); delayed_trigger = 0;
    chk("midrst_valid", photon_valid_o, 0);
    chk("midrst_event", event_cnt_o, 0);
    chk("midrst_hist_sum", hist_sum(), 0);

    // 3 MHz sine sampled at 125 MHz, periodic windows.
    do_reset();
    for (int n = 0; n < 1000; n++) begin
      sample = 14'($rtoi(4000.0 + 4000.0 * $sin(2.0 * 3.14159265358979 * 3.0 * n / 125.0) + 0.5));
      trigger = ((n % 256) == 0);
      delayed_trigger = ((n % 256) == 10);
      step();
    end
    trigger = 0; delayed_trigger = 0;
    chk("sine_hist_sum", hist_sum(), longint'(event_cnt_o));
    chk("sine_event", event_cnt_o, 4);
    chk("sine_restart", restart_cnt_o, 0);

    // Random traffic, threshold changes and occasional resets.
    do_reset();
    repeat (2000) begin
      rstn_i = ($urandom_range(0, 299) != 0);
      trigger = ($urandom_range(0, 11) == 0);
      delayed_trigger = ($urandom_range(0, 7) == 0);
      sample = 14'($urandom_range(0, 16383));
      if ($urandom_range(0, 31) == 0) begin
        idx = int'($urandom_range(0, 7));
        thr[idx] = 14'($urandom_range(0, 16383));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
